// File: rtl/variable_part_insert_and_extend.sv
// variable_part_insert_and_extend: sign-extends a narrow sample and places it at a runtime bit offset in a wider word
module variable_part_insert_and_extend #(
    parameter int WIDTH_IN    = 24,
    parameter int WIDTH_OUT   = 31,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_i,
    input  logic                   set_stb_i,
    input  logic [INDEX_WIDTH-1:0] set_idx_i,
    input  logic [WIDTH_IN-1:0]    signal_in_i,
    input  logic                   strobe_in_i,
    output logic [WIDTH_OUT-1:0]   signal_out_o,
    output logic                   strobe_out_o,
    output logic                   idx_clamped_o
);
    localparam int MAXIDX = WIDTH_OUT - WIDTH_IN;
    localparam logic [INDEX_WIDTH-1:0] MAXIDX_I = INDEX_WIDTH'(MAXIDX);

    logic [INDEX_WIDTH-1:0] cur_idx_q, cur_idx_d, pend_idx_q, pend_idx_d, s1_idx_q;
    logic                   pend_q, pend_d, clamped_q, clamped_d, s1_vld_q, strobe_q;
    logic [WIDTH_IN-1:0]    s1_data_q;
    logic [WIDTH_OUT-1:0]   ext, out_q;
    logic                   over, apply, take;

    // Index control next state: the pending request moves into cur_idx only between samples
    always_comb begin
        over       = int'(set_idx_i) > MAXIDX;
        apply      = pend_q && (!run_i || !strobe_in_i);
        take       = strobe_in_i && run_i;
        cur_idx_d  = apply ? pend_idx_q : cur_idx_q;
        pend_idx_d = set_stb_i ? (over ? MAXIDX_I : set_idx_i) : pend_idx_q;
        pend_d     = set_stb_i || (pend_q && !apply);
        clamped_d  = clamped_q || (set_stb_i && over);
        ext        = {{MAXIDX{s1_data_q[WIDTH_IN-1]}}, s1_data_q};
    end

    // Index control registers; a new request landing on the apply cycle stays pending
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_idx_q  <= '0;
            pend_idx_q <= '0;
            pend_q     <= 1'b0;
            clamped_q  <= 1'b0;
        end else begin
            cur_idx_q  <= cur_idx_d;
            pend_idx_q <= pend_idx_d;
            pend_q     <= pend_d;
            clamped_q  <= clamped_d;
        end
    end

    // Stage 1: capture the sample together with the index it must use
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_idx_q  <= '0;
        end else begin
            s1_vld_q <= take;
            if (take) begin
                s1_data_q <= signal_in_i;
                s1_idx_q  <= cur_idx_q;
            end
        end
    end

    // Stage 2: sign-extend and shift; run low drops the in-flight sample and holds the output
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= s1_vld_q && run_i;
            if (s1_vld_q && run_i) out_q <= ext << s1_idx_q;
        end
    end

    assign signal_out_o  = out_q;
    assign strobe_out_o  = strobe_q;
    assign idx_clamped_o = clamped_q;
endmodule

// File: tb/tb_variable_part_insert_and_extend.sv
// tb_variable_part_insert_and_extend: scoreboard bench for a 31-bit and a 28-bit instance driven in parallel
module tb_variable_part_insert_and_extend;
    typedef struct { logic [30:0] v; int due; } ent_t;

    logic        clk = 0, rst = 1, run = 0, set_stb = 0, strobe_in = 0;
    logic [2:0]  set_idx = 0;
    logic [23:0] signal_in = 0;
    logic [30:0] siga;
    logic [27:0] sigb;
    logic        soa, sob, cla, clb;
    int          n = 0, nf = 0, cyc = 0;
    bit          started = 0;
    ent_t        sb[2][$];
    int          m_cur[2], m_pidx[2];
    bit          m_clamp[2];
    bit          m_pend;
    logic [30:0] lastv[2];

    variable_part_insert_and_extend dut_a (
        .clk(clk), .rst(rst), .run_i(run), .set_stb_i(set_stb), .set_idx_i(set_idx),
        .signal_in_i(signal_in), .strobe_in_i(strobe_in),
        .signal_out_o(siga), .strobe_out_o(soa), .idx_clamped_o(cla)
    );

    variable_part_insert_and_extend #(.WIDTH_OUT(28)) dut_b (
        .clk(clk), .rst(rst), .run_i(run), .set_stb_i(set_stb), .set_idx_i(set_idx),
        .signal_in_i(signal_in), .strobe_in_i(strobe_in),
        .signal_out_o(sigb), .strobe_out_o(sob), .idx_clamped_o(clb)
    );

    always #5 clk = ~clk;

    function automatic int maxi(input int k);
        return k == 0 ? 7 : 4;
    endfunction

    function automatic int wo(input int k);
        return k == 0 ? 31 : 28;
    endfunction

    // Reference value: the sample as a signed integer times 2**shift, kept to the output width
    function automatic logic [30:0] expv(input logic [23:0] d, input int sh, input int w);
        longint s;
        s = longint'($signed(d)) * (longint'(1) << sh);
        return 31'(s & ((longint'(1) << w) - 1));
    endfunction

    task automatic chk(input string nm, input logic [30:0] a, input logic [30:0] e);
        n++;
        if (a !== e) begin
            nf++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Drive one cycle of inputs, then advance the reference model at that edge
    task automatic step(input bit r, input bit rn, input bit ss, input logic [2:0] si,
                        input logic [23:0] d, input bit st);
        rst = r; run = rn; set_stb = ss; set_idx = si; signal_in = d; strobe_in = st;
        @(posedge clk);
        cyc++;
        if (r) started = 1;
        for (int k = 0; k < 2; k++) begin
            if (r || !rn)
                while (sb[k].size() != 0 && sb[k][$].due >= cyc) void'(sb[k].pop_back());
            if (r) begin
                m_cur[k] = 0; m_pidx[k] = 0; m_clamp[k] = 0; lastv[k] = 0;
            end else begin
                if (st && rn) sb[k].push_back('{v: expv(d, m_cur[k], wo(k)), due: cyc + 1});
                if (m_pend && (!rn || !st)) m_cur[k] = m_pidx[k];
                if (ss) begin
                    m_pidx[k] = int'(si) > maxi(k) ? maxi(k) : int'(si);
                    if (int'(si) > maxi(k)) m_clamp[k] = 1;
                end
            end
        end
        m_pend = r ? 0 : ss ? 1 : (m_pend && (!rn || !st)) ? 0 : m_pend;
        #2;
    endtask

    // Monitor: pop the scoreboard on every output strobe, otherwise the output must hold
    always @(posedge clk) begin
        #1;
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic        so, cl;
                logic [30:0] sv;
                ent_t        e;
                so = k == 0 ? soa : sob;
                cl = k == 0 ? cla : clb;
                sv = k == 0 ? siga : {3'b0, sigb};
                n++;
                if (so) begin
                    if (sb[k].size() == 0 || sb[k][0].due != cyc) begin
                        nf++;
                        $display("FAIL unexpected_strobe dut%0d cyc %0d: got strobe 1 expected 0", k, cyc);
                    end else begin
                        e = sb[k].pop_front();
                        lastv[k] = e.v;
                        if (sv !== e.v) begin
                            nf++;
                            $display("FAIL sample dut%0d cyc %0d: got %h expected %h", k, cyc, sv, e.v);
                        end
                    end
                end else if (sb[k].size() != 0 && sb[k][0].due <= cyc) begin
                    nf++;
                    $display("FAIL missing_strobe dut%0d cyc %0d: got strobe 0 expected 1", k, cyc);
                    void'(sb[k].pop_front());
                end else if (sv !== lastv[k]) begin
                    nf++;
                    $display("FAIL hold dut%0d cyc %0d: got %h expected %h", k, cyc, sv, lastv[k]);
                end
                n++;
                if (cl !== m_clamp[k]) begin
                    nf++;
                    $display("FAIL clamp dut%0d cyc %0d: got %b expected %b", k, cyc, cl, m_clamp[k]);
                end
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_sig", siga, 31'h0);
        chk("rst_stb", 31'(soa), 31'h0);
        chk("rst_clamp", 31'({cla, clb}), 31'h0);
        // single sample at shift 0
        step(0, 1, 0, 0, 24'h000001, 1);
        step(0, 1, 0, 0, 0, 0);
        chk("t1_out", siga, 31'h0000001);
        chk("t1_stb", 31'(soa), 31'h1);
        step(0, 1, 0, 0, 0, 0);
        chk("t1_pulse", 31'(soa), 31'h0);
        // shift 7 with extreme samples
        step(0, 1, 1, 3'd7, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 24'h800000, 1);
        step(0, 1, 0, 0, 24'h7FFFFF, 1);
        chk("t2_neg", siga, 31'h40000000);
        step(0, 1, 0, 0, 0, 0);
        chk("t2_pos", siga, 31'h3FFFFF80);
        // set_stb coincident with a sample uses the old index
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 3'd3, 24'h000010, 1);
        step(0, 1, 0, 0, 0, 0);
        chk("t3_old", siga, 31'h0000010);
        step(0, 1, 0, 0, 24'h000010, 1);
        step(0, 1, 0, 0, 0, 0);
        chk("t3_new", siga, 31'h0000080);
        // clamping on the narrower instance
        step(0, 1, 1, 3'd6, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 24'hFFFFFF, 1);
        step(0, 1, 0, 0, 0, 0);
        chk("t4_b", {3'b0, sigb}, 31'h0FFFFFF0);
        chk("t4_a", siga, 31'h7FFFFFC0);
        chk("t4_clamp", 31'(clb), 31'h1);
        step(0, 1, 1, 3'd2, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("t4_sticky", 31'(clb), 31'h1);
        // continuous strobes defer the index change to the first gap
        step(0, 1, 1, 3'd0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, i == 2, 3'd2, 24'h000001, 1);
        chk("t5_defer", siga, 31'h0000001);
        step(0, 1, 0, 0, 0, 0);
        chk("t5_last_old", siga, 31'h0000001);
        step(0, 1, 0, 0, 24'h000001, 1);
        step(0, 1, 0, 0, 0, 0);
        chk("t5_new", siga, 31'h0000004);
        // run drop, then reset, one cycle after a sample
        step(0, 1, 0, 0, 24'h000005, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("t6_run_stb", 31'(soa), 31'h0);
        chk("t6_run_hold", siga, 31'h0000004);
        step(0, 1, 0, 0, 0, 0);
        chk("t6_run_stb2", 31'(soa), 31'h0);
        step(0, 1, 0, 0, 24'h000006, 1);
        step(1, 1, 0, 0, 0, 0);
        chk("t6_rst_stb", 31'(soa), 31'h0);
        chk("t6_rst_sig", siga, 31'h0);
        chk("t6_rst_clamp", 31'({cla, clb}), 31'h0);
        step(0, 1, 0, 0, 24'h000001, 1);
        step(0, 1, 0, 0, 0, 0);
        chk("t6_rst_idx", siga, 31'h0000001);
        // randomized traffic
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                 3'($urandom_range(0, 7)), 24'($urandom), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        chk("drain_a", 31'(sb[0].size()), 31'h0);
        chk("drain_b", 31'(sb[1].size()), 31'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
        $finish;
    end
endmodule
